image_write: RTL and testbench



---
 rtl/img_pkg.sv | 35 +++
 rtl/frame_buf_ram.sv | 30 +++
 rtl/image_write.sv | 225 ++++++++++++++++++++++
 tb/tb_image_write.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared definitions for the image reader/writer pair: frame size defaults,
// FSM encoding, and byte-lane layout of a 48-bit two-pixel word.
package img_pkg;

    localparam int WIDTH_DEF  = 956;
    localparam int HEIGHT_DEF = 635;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [2:0] LANE_B0 = 3'd0;
    localparam logic [2:0] LANE_G0 = 3'd1;
    localparam logic [2:0] LANE_R0 = 3'd2;
    localparam logic [2:0] LANE_B1 = 3'd3;
    localparam logic [2:0] LANE_G1 = 3'd4;
    localparam logic [2:0] LANE_R1 = 3'd5;

    function automatic int word_count(input int w, input int h);
        return (w * h) / 2;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [47:0] w, input logic [2:0] l);
        case (l)
            LANE_B0: lane_byte = w[7:0];
            LANE_G0: lane_byte = w[15:8];
            LANE_R0: lane_byte = w[23:16];
            LANE_B1: lane_byte = w[31:24];
            LANE_G1: lane_byte = w[39:32];
            default: lane_byte = w[47:40];
        endcase
    endfunction

endpackage

// File: rtl/frame_buf_ram.sv
// Frame buffer: one write port, one synchronous read port (1-cycle latency).
// The array is deliberately not reset.
module frame_buf_ram
    import img_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 48
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/image_write.sv
// Pixel-stream sink: captures one frame bottom-up into the frame buffer, then
// drains it as a B,G,R-ordered valid/ready byte stream.
//   state      | meaning
//   ST_IDLE    | waiting for the first frame-start
//   ST_CAPTURE | writing HSYNC beats into the buffer
//   ST_DRAIN   | streaming bytes out, word 0 upward
//   ST_DONE    | frame drained, frame_done held
module image_write
    import img_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HEIGHT = HEIGHT_DEF
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       VSYNC,
    input  logic       HSYNC,
    input  logic [7:0] DATA_R0,
    input  logic [7:0] DATA_G0,
    input  logic [7:0] DATA_B0,
    input  logic [7:0] DATA_R1,
    input  logic [7:0] DATA_G1,
    input  logic [7:0] DATA_B1,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [7:0] rd_data,
    output logic       rd_last,
    output logic       frame_done,
    output logic       overflow_err
);

    localparam int WORDS = word_count(WIDTH, HEIGHT);
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int AW1   = AW + 1;
    localparam int HALF  = WIDTH / 2;

    localparam logic [RW-1:0]  ROW_LAST  = RW'(HEIGHT - 1);
    localparam logic [CW-1:0]  COL_LAST  = CW'(WIDTH - 2);
    localparam logic [AW-1:0]  WORD_LAST = AW'(WORDS - 1);
    localparam logic [AW1-1:0] FETCH_END = AW1'(WORDS);

    logic [1:0]     state_q, state_d;
    logic           vsync_q;
    logic [RW-1:0]  row_q, row_d;
    logic [CW-1:0]  col_q, col_d;
    logic [AW-1:0]  word_q, word_d;
    logic [2:0]     lane_q, lane_d;
    logic [AW1-1:0] fetch_q, fetch_d;
    logic [47:0]    cur_q, cur_d;
    logic           start_q, start_d;
    logic           load_q, load_d;
    logic           rd_valid_q, rd_valid_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic           rd_last_q, rd_last_d;
    logic           frame_done_q, frame_done_d;
    logic           ovf_q, ovf_d;

    logic           ram_we, ram_re;
    logic [AW-1:0]  ram_waddr, ram_raddr;
    logic [47:0]    ram_wdata, ram_rdata;
    logic           frame_start, last_beat, accept;
    logic [2:0]     lane_nxt;

    assign frame_start = VSYNC & ~vsync_q;
    assign last_beat   = HSYNC && (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign accept      = rd_valid_q && rd_ready;
    assign lane_nxt    = lane_q + 3'd1;

    // Bottom-up row placement: row 0 of the source lands in the last buffer row.
    assign ram_waddr = AW'((HEIGHT - 1 - int'(row_q)) * HALF + int'(col_q >> 1));
    assign ram_wdata = {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};

    frame_buf_ram #(
        .DEPTH (WORDS),
        .AW    (AW),
        .DW    (48)
    ) u_ram (
        .clk_i   (HCLK),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (frame_start) state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                if (frame_start)    state_d = ST_CAPTURE;
                else if (last_beat) state_d = ST_DRAIN;
            end
            ST_DRAIN:   if (accept && rd_last_q) state_d = ST_DONE;
            ST_DONE:    if (frame_start) state_d = ST_CAPTURE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        row_d        = row_q;
        col_d        = col_q;
        word_d       = word_q;
        lane_d       = lane_q;
        fetch_d      = fetch_q;
        cur_d        = cur_q;
        load_d       = 1'b0;
        rd_valid_d   = rd_valid_q;
        rd_data_d    = rd_data_q;
        rd_last_d    = rd_last_q;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_raddr    = fetch_q[AW-1:0];
        start_d      = (state_q == ST_CAPTURE) && (state_d == ST_DRAIN);
        frame_done_d = (state_d == ST_DONE);
        ovf_d        = ovf_q | (HSYNC && (state_q != ST_CAPTURE));

        // A frame-start wins over a beat arriving in the same cycle.
        if (frame_start && (state_q != ST_DRAIN)) begin
            row_d = '0;
            col_d = '0;
        end else if ((state_q == ST_CAPTURE) && HSYNC) begin
            ram_we = 1'b1;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(2);
            end
        end

        if (start_q) begin
            ram_re    = 1'b1;
            ram_raddr = '0;
            fetch_d   = AW1'(1);
            load_d    = 1'b1;
        end

        // cur_q holds the word being emitted; the RAM output register holds
        // the prefetched next word until lane 5 is accepted.
        if (load_q) begin
            cur_d      = ram_rdata;
            rd_data_d  = lane_byte(ram_rdata, LANE_B0);
            lane_d     = LANE_B0;
            word_d     = '0;
            rd_valid_d = 1'b1;
            rd_last_d  = 1'b0;
            if (fetch_q < FETCH_END) begin
                ram_re  = 1'b1;
                fetch_d = fetch_q + AW1'(1);
            end
        end else if (accept) begin
            if (lane_q != LANE_R1) begin
                lane_d    = lane_nxt;
                rd_data_d = lane_byte(cur_q, lane_nxt);
                rd_last_d = (word_q == WORD_LAST) && (lane_nxt == LANE_R1);
            end else if (rd_last_q) begin
                rd_valid_d = 1'b0;
                rd_last_d  = 1'b0;
            end else begin
                cur_d     = ram_rdata;
                rd_data_d = lane_byte(ram_rdata, LANE_B0);
                lane_d    = LANE_B0;
                word_d    = word_q + AW'(1);
                rd_last_d = 1'b0;
                if (fetch_q < FETCH_END) begin
                    ram_re  = 1'b1;
                    fetch_d = fetch_q + AW1'(1);
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            vsync_q      <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            word_q       <= '0;
            lane_q       <= '0;
            fetch_q      <= '0;
            cur_q        <= '0;
            start_q      <= 1'b0;
            load_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            vsync_q      <= VSYNC;
            row_q        <= row_d;
            col_q        <= col_d;
            word_q       <= word_d;
            lane_q       <= lane_d;
            fetch_q      <= fetch_d;
            cur_q        <= cur_d;
            start_q      <= start_d;
            load_q       <= load_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_last_q    <= rd_last_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_last      = rd_last_q;
    assign frame_done   = frame_done_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_image_write.sv
// Bench for image_write on a 4x2 frame: scenario table plus hand-written
// restart and async-reset sequences, checked against a BMP-order model.
module tb_image_write;

    localparam int W      = 4;
    localparam int H      = 2;
    localparam int NPIX   = W * H;
    localparam int NBEATS = NPIX / 2;
    localparam int NBYTES = NPIX * 3;
    localparam int BUDGET = 2000;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b1;
    logic       VSYNC = 1'b0;
    logic       HSYNC = 1'b0;
    logic [7:0] DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
    logic [7:0] DATA_R1 = '0, DATA_G1 = '0, DATA_B1 = '0;
    logic       rd_ready = 1'b0;
    logic       rd_valid, rd_last, frame_done, overflow_err;
    logic [7:0] rd_data;

    always #5 HCLK = ~HCLK;

    image_write #(.WIDTH(W), .HEIGHT(H)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .VSYNC        (VSYNC),
        .HSYNC        (HSYNC),
        .DATA_R0      (DATA_R0),
        .DATA_G0      (DATA_G0),
        .DATA_B0      (DATA_B0),
        .DATA_R1      (DATA_R1),
        .DATA_G1      (DATA_G1),
        .DATA_B1      (DATA_B1),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .frame_done   (frame_done),
        .overflow_err (overflow_err)
    );

    typedef struct {
        int gap;        // idle HSYNC cycles between beats
        int ready_mode; // 0: always ready, 1: 1,0,0,1 pattern, 2: random
        bit spec_pix;   // use the documented pixel pattern
        bit hs_drain;   // inject an HSYNC beat while draining
        bit exp_ovf;    // overflow_err expected after the frame
    } scen_t;

    scen_t      scen [5];
    logic [7:0] pr [NPIX], pg [NPIX], pb [NPIX];
    logic [7:0] expq [$];
    logic [7:0] gotd [$];
    logic       gotl [$];
    logic [7:0] spec_exp [NBYTES] = '{53,52,51,63,62,61,73,72,71,83,82,81,
                                      13,12,11,23,22,21,33,32,31,43,42,41};
    int n_chk  = 0;
    int n_pass = 0;
    int first_cyc;
    int bubbles;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fill_spec();
        for (int p = 0; p < NPIX; p++) begin
            pr[p] = 8'(10 * (p + 1) + 1);
            pg[p] = 8'(10 * (p + 1) + 2);
            pb[p] = 8'(10 * (p + 1) + 3);
        end
    endtask

    task automatic fill_rand();
        for (int p = 0; p < NPIX; p++) begin
            pr[p] = 8'($urandom);
            pg[p] = 8'($urandom);
            pb[p] = 8'($urandom);
        end
    endtask

    // BMP pixel array: last image row first, each pixel as B,G,R.
    task automatic build_model();
        expq.delete();
        for (int r = H - 1; r >= 0; r--)
            for (int x = 0; x < W; x++) begin
                expq.push_back(pb[r * W + x]);
                expq.push_back(pg[r * W + x]);
                expq.push_back(pr[r * W + x]);
            end
    endtask

    task automatic rand_data();
        {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1} = {$urandom, 16'($urandom)};
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic vsync_pulse(input bit hs_on_edge);
        VSYNC = 1'b1;
        if (hs_on_edge) begin
            HSYNC = 1'b1;
            rand_data();
        end
        tick();
        VSYNC = 1'b0;
        HSYNC = 1'b0;
    endtask

    task automatic drive_beat(input int k);
        DATA_R0 = pr[2 * k];     DATA_G0 = pg[2 * k];     DATA_B0 = pb[2 * k];
        DATA_R1 = pr[2 * k + 1]; DATA_G1 = pg[2 * k + 1]; DATA_B1 = pb[2 * k + 1];
        HSYNC = 1'b1;
        tick();
        HSYNC = 1'b0;
    endtask

    task automatic send_frame(input int gap, input int pre_beats);
        if (pre_beats > 0) begin
            vsync_pulse(1'b0);
            for (int i = 0; i < pre_beats; i++) begin
                rand_data();
                HSYNC = 1'b1;
                tick();
                HSYNC = 1'b0;
            end
        end
        vsync_pulse(pre_beats > 0);
        for (int k = 0; k < NBEATS; k++) begin
            drive_beat(k);
            if (k != NBEATS - 1) repeat (gap) tick();
        end
    endtask

    task automatic collect(input int mode, input bit hs_drain);
        int cyc = 0;
        int last_acc = -1;
        bit done = 1'b0;
        bit stall = 1'b0;
        logic [7:0] pd = '0;
        logic pl = 1'b0;
        gotd.delete();
        gotl.delete();
        first_cyc = -1;
        bubbles = 0;
        while (!done && cyc < BUDGET) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            if (hs_drain) begin
                HSYNC = (cyc == 3);
                if (cyc == 3) rand_data();
            end
            if (stall) check("stall_hold", 64'({rd_data, rd_last}), 64'({pd, pl}));
            if (rd_valid && first_cyc < 0) first_cyc = cyc;
            if (rd_valid && rd_ready) begin
                if (last_acc >= 0 && cyc != last_acc + 1) bubbles++;
                last_acc = cyc;
                gotd.push_back(rd_data);
                gotl.push_back(rd_last);
                if (rd_last) done = 1'b1;
            end
            stall = rd_valid && !rd_ready;
            pd = rd_data;
            pl = rd_last;
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        HSYNC = 1'b0;
        if (!done) check("drain_timeout", 64'(done), 64'(1));
    endtask

    task automatic verify(input string tag, input bit use_spec);
        logic [7:0] e;
        check({tag, "_byte_count"}, 64'(gotd.size()), 64'(NBYTES));
        for (int i = 0; i < NBYTES && i < gotd.size(); i++) begin
            e = use_spec ? spec_exp[i] : expq[i];
            check($sformatf("%s_byte%0d{data,last}", tag, i),
                  64'({gotd[i], gotl[i]}), 64'({e, (i == NBYTES - 1)}));
        end
        check({tag, "_frame_done"}, 64'(frame_done), 64'(1));
        check({tag, "_valid_drop"}, 64'(rd_valid), 64'(0));
    endtask

    initial begin
        int w;
        scen[0] = '{gap: 0, ready_mode: 0, spec_pix: 1, hs_drain: 0, exp_ovf: 0};
        scen[1] = '{gap: 0, ready_mode: 1, spec_pix: 1, hs_drain: 0, exp_ovf: 0};
        scen[2] = '{gap: 3, ready_mode: 0, spec_pix: 1, hs_drain: 0, exp_ovf: 0};
        scen[3] = '{gap: 0, ready_mode: 0, spec_pix: 0, hs_drain: 1, exp_ovf: 1};
        scen[4] = '{gap: 1, ready_mode: 2, spec_pix: 0, hs_drain: 0, exp_ovf: 1};

        #1 HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        check("reset_outputs", 64'({rd_valid, rd_data, rd_last, frame_done, overflow_err}), 64'(0));
        HRESETn = 1'b1;
        tick();

        // Restart mid-capture, with a beat coinciding with the new frame-start.
        fill_spec();
        send_frame(0, 2);
        collect(0, 1'b0);
        verify("restart", 1'b1);
        check("restart_no_ovf", 64'(overflow_err), 64'(0));

        for (int s = 0; s < 5; s++) begin
            if (scen[s].spec_pix) fill_spec();
            else fill_rand();
            build_model();
            send_frame(scen[s].gap, 0);
            collect(scen[s].ready_mode, scen[s].hs_drain);
            verify($sformatf("scen%0d", s), scen[s].spec_pix);
            check($sformatf("scen%0d_first_valid", s), 64'(first_cyc), 64'(2));
            if (scen[s].ready_mode == 0)
                check($sformatf("scen%0d_bubbles", s), 64'(bubbles), 64'(0));
            check($sformatf("scen%0d_overflow", s), 64'(overflow_err), 64'(scen[s].exp_ovf));
        end

        // Asynchronous reset in the middle of a drain.
        fill_rand();
        send_frame(0, 0);
        rd_ready = 1'b1;
        w = 0;
        while (!rd_valid && w < 20) begin
            tick();
            w++;
        end
        check("mid_drain_started", 64'(rd_valid), 64'(1));
        repeat (3) tick();
        #3 HRESETn = 1'b0;
        #1;
        check("async_reset_outputs", 64'({rd_valid, rd_data, rd_last, frame_done, overflow_err}), 64'(0));
        rd_ready = 1'b0;
        tick();
        HRESETn = 1'b1;
        tick();

        fill_rand();
        build_model();
        send_frame(1, 0);
        collect(2, 1'b0);
        verify("post_reset", 1'b0);
        check("post_reset_ovf", 64'(overflow_err), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
